pc_fetch_unit: RTL

Instruction-fetch stage that sits directly upstream of the instruction memory. It holds the program counter, drives the byte read address into the instruction memory, and computes the next PC from sequential, branch and jump sources. It also captures the returned instruction into an IF/ID pipeline register with a valid bit, stall and flush control. A saturating fetch counter supports debug.

---
 rtl/pc_fetch_unit.sv | 97 +++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, next-PC selection (sequential, branch, jump) and the
// IF/ID pipeline register with stall/flush, plus a saturating debug fetch counter.
module pc_fetch_unit #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] read_addr,
  output logic [31:0]       if_instruction,
  output logic [ADDR_W-1:0] if_pc_plus4,
  output logic              if_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [31:0]       RESET_PC_V = RESET_PC;
  localparam logic [ADDR_W-1:0] RST_PC     = {RESET_PC_V[ADDR_W-1:2], 2'b00};

  logic [ADDR_W-1:0] r_pc,    w_pc_d;
  logic [31:0]       r_ins,   w_ins_d;
  logic [ADDR_W-1:0] r_pc4,   w_pc4_d;
  logic              r_valid, w_valid_d;
  logic [CNT_W-1:0]  r_cnt,   w_cnt_d;

  logic [ADDR_W-1:0] w_pc_plus4;
  logic [31:0]       w_off_ext;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic              w_do_jump;
  logic              w_do_branch;
  logic              w_unused;

  assign w_pc_plus4  = r_pc + ADDR_W'(4);
  // Word offset scaled to bytes; only the low ADDR_W bits matter after wrap-around.
  assign w_off_ext   = {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign w_br_tgt    = r_pc4 + w_off_ext[ADDR_W-1:0];
  assign w_jmp_tgt   = {jump_target[ADDR_W-3:0], 2'b00};
  // Redirects only apply to a real instruction sitting in IF/ID.
  assign w_do_jump   = r_valid & jump;
  assign w_do_branch = r_valid & branch_taken;
  assign w_unused    = ^{jump_target[25:ADDR_W-2], w_off_ext[31:ADDR_W]};

  always_comb begin
    w_pc_d    = r_pc;
    w_ins_d   = r_ins;
    w_pc4_d   = r_pc4;
    w_valid_d = r_valid;
    w_cnt_d   = r_cnt;
    if (w_do_jump) begin
      w_pc_d    = w_jmp_tgt;
      w_ins_d   = '0;
      w_valid_d = 1'b0;
    end else if (w_do_branch) begin
      w_pc_d    = w_br_tgt;
      w_ins_d   = '0;
      w_valid_d = 1'b0;
    end else if (!stall) begin
      w_pc_d    = w_pc_plus4;
      w_ins_d   = instruction;
      w_pc4_d   = w_pc_plus4;
      w_valid_d = 1'b1;
      if (r_cnt != {CNT_W{1'b1}}) begin
        w_cnt_d = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= RST_PC;
      r_ins   <= '0;
      r_pc4   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_pc_d;
      r_ins   <= w_ins_d;
      r_pc4   <= w_pc4_d;
      r_valid <= w_valid_d;
      r_cnt   <= w_cnt_d;
    end
  end

  assign read_addr      = r_pc;
  assign if_instruction = r_ins;
  assign if_pc_plus4    = r_pc4;
  assign if_valid       = r_valid;
  assign fetch_count    = r_cnt;

endmodule
